circuit1_seq_ctrl: RTL

- Resource-constrained, FSM-sequenced implementation of the Circuit1 dataflow.
- Computes d=a+b, e=a+c, f=a-b, then the compare, select and shift stages.
- Uses one shared adder/subtractor scheduled over multiple cycles instead of three parallel units.
- Start/Done handshake; sits between a host sequencer and the downstream register consumers of x and z.

---
 rtl/circuit1_seq_ctrl_if.sv | 25 ++
 rtl/circuit1_seq_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/circuit1_seq_ctrl_if.sv
// Host-side bus for circuit1_seq_ctrl: Start/Done handshake, operands and results.
interface circuit1_seq_ctrl_if #(
    parameter int DATAWIDTH = 32
);
    logic                 Start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] z;
    logic                 Busy;
    logic                 Done;

    // Host sequencer drives operands and Start, consumes results.
    modport master (
        output Start, a, b, c,
        input  x, z, Busy, Done
    );

    // The datapath controller receives operands and produces results.
    modport slave (
        input  Start, a, b, c,
        output x, z, Busy, Done
    );
endinterface

// File: rtl/circuit1_seq_ctrl.sv
// Circuit1 dataflow computed over several cycles with one shared add/sub unit.
// d=a+b, e=a+c, f=a-b, then select g/h by comparing d and e, then shift into x/z.
module circuit1_seq_ctrl #(
    parameter int DATAWIDTH = 32
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    circuit1_seq_ctrl_if.slave s_bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OP_D     = 3'd1,
        OP_E     = 3'd2,
        OP_F     = 3'd3,
        OP_SEL   = 3'd4,
        OP_SHIFT = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_a;
    logic [DATAWIDTH-1:0] r_b;
    logic [DATAWIDTH-1:0] r_c;
    logic [DATAWIDTH-1:0] r_d;
    logic [DATAWIDTH-1:0] r_e;
    logic [DATAWIDTH-1:0] r_f;
    logic [DATAWIDTH-1:0] r_g;
    logic [DATAWIDTH-1:0] r_h;
    logic                 r_dLTe;
    logic                 r_dEQe;
    logic [DATAWIDTH-1:0] r_x;
    logic [DATAWIDTH-1:0] r_z;
    logic                 r_busy;
    logic                 r_done;

    logic [DATAWIDTH-1:0] w_aluA;
    logic [DATAWIDTH-1:0] w_aluB;
    logic                 w_aluSub;
    logic [DATAWIDTH-1:0] w_aluB2;
    logic [DATAWIDTH-1:0] w_aluCin;
    logic [DATAWIDTH-1:0] w_aluResult;
    logic                 w_dLTe;
    logic                 w_dEQe;

    // Operand routing for the shared ALU; subtraction is selected only in OP_F.
    always_comb begin
        w_aluA   = r_a;
        w_aluB   = r_b;
        w_aluSub = 1'b0;
        case (r_state)
            OP_E:    w_aluB   = r_c;
            OP_F:    w_aluSub = 1'b1;
            default: ;
        endcase
    end

    // Single adder: subtraction is a + ~b + 1, so add and sub share one carry chain.
    assign w_aluB2     = w_aluSub ? ~w_aluB : w_aluB;
    assign w_aluCin    = {{(DATAWIDTH-1){1'b0}}, w_aluSub};
    assign w_aluResult = w_aluA + w_aluB2 + w_aluCin;

    // Single unsigned comparator; its result is only captured in OP_SEL.
    assign w_dLTe = (r_d < r_e);
    assign w_dEQe = (r_d == r_e);

    // Sequencer, datapath registers and registered handshake outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            r_f     <= '0;
            r_g     <= '0;
            r_h     <= '0;
            r_dLTe  <= 1'b0;
            r_dEQe  <= 1'b0;
            r_x     <= '0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (s_bus.Start) begin
                        r_a     <= s_bus.a;
                        r_b     <= s_bus.b;
                        r_c     <= s_bus.c;
                        r_busy  <= 1'b1;
                        r_state <= OP_D;
                    end
                end
                OP_D: begin
                    r_d     <= w_aluResult;
                    r_state <= OP_E;
                end
                OP_E: begin
                    r_e     <= w_aluResult;
                    r_state <= OP_F;
                end
                OP_F: begin
                    r_f     <= w_aluResult;
                    r_state <= OP_SEL;
                end
                OP_SEL: begin
                    r_dLTe  <= w_dLTe;
                    r_dEQe  <= w_dEQe;
                    r_g     <= w_dLTe ? r_e : r_d;
                    r_h     <= w_dEQe ? r_f : (w_dLTe ? r_e : r_d);
                    r_state <= OP_SHIFT;
                end
                OP_SHIFT: begin
                    r_x     <= r_g << r_dLTe;
                    r_z     <= r_h >> r_dEQe;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_bus.x    = r_x;
    assign s_bus.z    = r_z;
    assign s_bus.Busy = r_busy;
    assign s_bus.Done = r_done;

endmodule
